// File: rtl/taiga_types.sv
// Shared types and limits for the multi-retire writeback block.
package taiga_types;

    // Upper limits the writeback block is built to support.
    localparam int MAX_RETIRE_WIDTH = 4;
    localparam int MAX_ID_W         = 5;   // 32 inflight IDs
    localparam int MAX_XLEN         = 64;

    // Instruction ID, sized for the largest supported ID space.
    typedef logic [MAX_ID_W-1:0] wb_id_t;

    // One retire lane. Narrower configurations zero-extend into these fields.
    typedef struct packed {
        logic                valid;
        logic                is_store;
        wb_id_t              id;
        logic [4:0]          rd_addr;
        logic [MAX_XLEN-1:0] rd_data;
        logic [31:0]         pc;
    } retire_slot_t;

endpackage

// File: rtl/multi_retire_id_fifo.sv
// Circular ID allocator: allocate pointer, head (oldest) pointer and
// occupancy count, with a head that can advance by several IDs per cycle.
module multi_retire_id_fifo
    import taiga_types::*;
#(
    parameter int MAX_INFLIGHT = 8,
    parameter int RETIRE_WIDTH = 2,
    parameter int ID_W         = $clog2(MAX_INFLIGHT),
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1),
    parameter int K_W          = $clog2(RETIRE_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc,
    input  logic [K_W-1:0]   retire_k,
    output logic [ID_W-1:0]  alloc_ptr,
    output logic [ID_W-1:0]  oldest_ptr,
    output logic [CNT_W-1:0] count,
    output logic             id_available,
    output logic             empty
);

    // Pointer and count update; a flush rewinds allocation to the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr  <= '0;
            oldest_ptr <= '0;
            count      <= '0;
        end else if (flush) begin
            alloc_ptr <= oldest_ptr;
            count     <= '0;
        end else begin
            if (alloc) begin
                alloc_ptr <= alloc_ptr + ID_W'(1);
            end
            // ID space is a power of two, so the add wraps naturally.
            oldest_ptr <= oldest_ptr + ID_W'(retire_k);
            count      <= count + CNT_W'(alloc) - CNT_W'(retire_k);
        end
    end

    // Availability comes from the registered count only, so a retire in
    // the current cycle does not free a slot until the next one.
    always_comb begin
        id_available = (count < CNT_W'(MAX_INFLIGHT));
        empty        = (count == '0);
    end

endmodule

// File: rtl/write_back_multi_retire.sv
// Multi-retire commit buffer: collects unit results per instruction ID and
// retires up to RETIRE_WIDTH consecutive completed IDs per cycle in order.
module write_back_multi_retire
    import taiga_types::*;
#(
    parameter int NUM_UNITS    = 4,
    parameter int MAX_INFLIGHT = 8,
    parameter int RETIRE_WIDTH = 2,
    parameter int XLEN         = 32,
    parameter int ID_W         = $clog2(MAX_INFLIGHT)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             issue_valid,
    input  logic [4:0]                       issue_rd_addr,
    input  logic                             issue_is_store,
    output logic [ID_W-1:0]                  issue_id,
    output logic                             id_available,
    input  logic [NUM_UNITS-1:0]             unit_done,
    input  logic [NUM_UNITS*ID_W-1:0]        unit_id,
    input  logic [NUM_UNITS*XLEN-1:0]        unit_rd,
    input  logic [NUM_UNITS*32-1:0]          unit_pc,
    input  logic                             store_complete,
    input  logic [ID_W-1:0]                  store_id,
    input  logic [31:0]                      store_pc,
    input  logic                             flush,
    output logic [RETIRE_WIDTH-1:0]          retire_valid,
    output logic [RETIRE_WIDTH-1:0]          retire_is_store,
    output logic [RETIRE_WIDTH*ID_W-1:0]     retire_id,
    output logic [RETIRE_WIDTH*5-1:0]        retire_rd_addr,
    output logic [RETIRE_WIDTH*XLEN-1:0]     retire_rd_data,
    output logic [RETIRE_WIDTH*32-1:0]       retire_pc,
    output logic [$clog2(RETIRE_WIDTH+1)-1:0] retire_count,
    input  logic [ID_W-1:0]                  rs1_id,
    input  logic [ID_W-1:0]                  rs2_id,
    output logic                             rs1_valid,
    output logic                             rs2_valid,
    output logic [XLEN-1:0]                  rs1_data,
    output logic [XLEN-1:0]                  rs2_data,
    output logic [ID_W-1:0]                  oldest_id,
    output logic                             empty
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int K_W   = $clog2(RETIRE_WIDTH + 1);

    logic [ID_W-1:0]   alloc_ptr;
    logic [ID_W-1:0]   oldest_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_issue;

    logic [MAX_INFLIGHT-1:0] inuse;
    logic [MAX_INFLIGHT-1:0] pending;
    logic [4:0]              rd_buf   [MAX_INFLIGHT];
    logic                    st_buf   [MAX_INFLIGHT];
    logic [XLEN-1:0]         data_buf [MAX_INFLIGHT];
    logic [31:0]             pc_buf   [MAX_INFLIGHT];

    logic [ID_W-1:0]   uid [NUM_UNITS];
    logic [ID_W-1:0]   slot_idx_p0 [RETIRE_WIDTH];
    logic [K_W-1:0]    k_p0;
    logic [K_W-1:0]    k_eff_p0;
    logic [K_W-1:0]    ns_cnt_p0;
    retire_slot_t      slot_p0 [RETIRE_WIDTH];

    logic [RETIRE_WIDTH-1:0] vld_p1;
    logic [K_W-1:0]          ns_cnt_p1;
    retire_slot_t            slot_p1 [RETIRE_WIDTH];
    logic                    slot_bits_unused;

    logic dup_hit;
    logic orphan_hit;

    // Flush takes priority over allocation and retirement.
    assign do_issue = issue_valid && id_available && !flush;
    assign k_eff_p0 = flush ? '0 : k_p0;

    multi_retire_id_fifo #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .RETIRE_WIDTH (RETIRE_WIDTH),
        .ID_W         (ID_W),
        .CNT_W        (CNT_W),
        .K_W          (K_W)
    ) u_id_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .alloc        (do_issue),
        .retire_k     (k_eff_p0),
        .alloc_ptr    (alloc_ptr),
        .oldest_ptr   (oldest_ptr),
        .count        (count),
        .id_available (id_available),
        .empty        (empty)
    );

    // Split the flattened unit ID bus and form the candidate retire IDs.
    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            uid[u] = unit_id[u*ID_W +: ID_W];
        end
        for (int s = 0; s < RETIRE_WIDTH; s++) begin
            slot_idx_p0[s] = oldest_ptr + ID_W'(s);
        end
    end

    // ---- p0: pick the run of completed IDs starting at the head ----
    // Count consecutive pending entries from the head, capped by occupancy.
    always_comb begin
        logic run;
        run       = 1'b1;
        k_p0      = '0;
        ns_cnt_p0 = '0;
        for (int s = 0; s < RETIRE_WIDTH; s++) begin
            if (run && pending[slot_idx_p0[s]] && (s < int'(count))) begin
                k_p0 = k_p0 + K_W'(1);
                if (!st_buf[slot_idx_p0[s]]) begin
                    ns_cnt_p0 = ns_cnt_p0 + K_W'(1);
                end
            end else begin
                run = 1'b0;
            end
        end
    end

    // Gather the buffered contents of each candidate lane.
    always_comb begin
        for (int s = 0; s < RETIRE_WIDTH; s++) begin
            slot_p0[s]          = '0;
            slot_p0[s].valid    = (s < int'(k_p0));
            slot_p0[s].is_store = st_buf[slot_idx_p0[s]];
            slot_p0[s].id       = MAX_ID_W'(slot_idx_p0[s]);
            slot_p0[s].rd_addr  = rd_buf[slot_idx_p0[s]];
            slot_p0[s].rd_data  = MAX_XLEN'(data_buf[slot_idx_p0[s]]);
            slot_p0[s].pc       = pc_buf[slot_idx_p0[s]];
        end
    end

    // ---- p1: registered retire lanes ----
    // Entry state and retire valids; clears for retiring IDs override sets.
    always_ff @(posedge clk) begin
        if (rst) begin
            inuse     <= '0;
            pending   <= '0;
            vld_p1    <= '0;
            ns_cnt_p1 <= '0;
        end else if (flush) begin
            inuse     <= '0;
            pending   <= '0;
            vld_p1    <= '0;
            ns_cnt_p1 <= '0;
        end else begin
            if (do_issue) begin
                inuse[alloc_ptr] <= 1'b1;
            end
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (unit_done[u] && inuse[uid[u]]) begin
                    pending[uid[u]] <= 1'b1;
                end
            end
            if (store_complete && inuse[store_id]) begin
                pending[store_id] <= 1'b1;
            end
            for (int s = 0; s < RETIRE_WIDTH; s++) begin
                if (slot_p0[s].valid) begin
                    inuse[slot_idx_p0[s]]   <= 1'b0;
                    pending[slot_idx_p0[s]] <= 1'b0;
                end
                vld_p1[s] <= slot_p0[s].valid;
            end
            ns_cnt_p1 <= ns_cnt_p0;
        end
    end

    // Result buffers and retire lane payload; iterating units from the top
    // down lets the lowest-numbered unit win when two report the same ID.
    always_ff @(posedge clk) begin
        if (do_issue) begin
            rd_buf[alloc_ptr] <= issue_rd_addr;
            st_buf[alloc_ptr] <= issue_is_store;
        end
        if (store_complete && inuse[store_id]) begin
            pc_buf[store_id] <= store_pc;
        end
        for (int u = NUM_UNITS - 1; u >= 0; u--) begin
            if (unit_done[u] && inuse[uid[u]]) begin
                data_buf[uid[u]] <= unit_rd[u*XLEN +: XLEN];
                pc_buf[uid[u]]   <= unit_pc[u*32 +: 32];
            end
        end
        for (int s = 0; s < RETIRE_WIDTH; s++) begin
            slot_p1[s] <= slot_p0[s];
        end
    end

    // Drive the flattened retire ports; stores never write a destination.
    always_comb begin
        slot_bits_unused = 1'b0;
        for (int s = 0; s < RETIRE_WIDTH; s++) begin
            retire_is_store[s]            = vld_p1[s] & slot_p1[s].is_store;
            retire_id[s*ID_W +: ID_W]     = slot_p1[s].id[ID_W-1:0];
            retire_rd_addr[s*5 +: 5]      = (vld_p1[s] && !slot_p1[s].is_store) ? slot_p1[s].rd_addr : 5'd0;
            retire_rd_data[s*XLEN +: XLEN] = slot_p1[s].rd_data[XLEN-1:0];
            retire_pc[s*32 +: 32]         = slot_p1[s].pc;
            slot_bits_unused              = slot_bits_unused ^ (^slot_p1[s]);
        end
    end

    assign retire_valid = vld_p1;
    assign retire_count = ns_cnt_p1;
    assign issue_id     = alloc_ptr;
    assign oldest_id    = oldest_ptr;

    // Operand bypass straight from the buffer.
    always_comb begin
        rs1_valid = pending[rs1_id];
        rs2_valid = pending[rs2_id];
        rs1_data  = data_buf[rs1_id];
        rs2_data  = data_buf[rs2_id];
    end

    // Detect colliding or stray completions for the checks below.
    always_comb begin
        dup_hit    = 1'b0;
        orphan_hit = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (unit_done[u] && !inuse[uid[u]]) begin
                orphan_hit = 1'b1;
            end
            for (int v = u + 1; v < NUM_UNITS; v++) begin
                if (unit_done[u] && unit_done[v] && (uid[u] == uid[v])) begin
                    dup_hit = 1'b1;
                end
            end
        end
        if (store_complete && !inuse[store_id]) begin
            orphan_hit = 1'b1;
        end
    end

    a_dup_done: assert property (@(posedge clk) disable iff (rst) !dup_hit)
        else $warning("write_back_multi_retire: two units reported the same ID; lowest unit kept");

    a_orphan_done: assert property (@(posedge clk) disable iff (rst) !orphan_hit)
        else $warning("write_back_multi_retire: completion for an ID that is not in use was dropped");

endmodule

// File: tb/tb_write_back_multi_retire.sv
// Directed bench for write_back_multi_retire (default parameters).
module tb_write_back_multi_retire;

    localparam int NU = 4;
    localparam int RW = 2;
    localparam int IW = 3;
    localparam int XL = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid;
    logic [4:0]      issue_rd_addr;
    logic            issue_is_store;
    logic [IW-1:0]   issue_id;
    logic            id_available;
    logic [NU-1:0]   unit_done;
    logic [NU*IW-1:0] unit_id;
    logic [NU*XL-1:0] unit_rd;
    logic [NU*32-1:0] unit_pc;
    logic            store_complete;
    logic [IW-1:0]   store_id;
    logic [31:0]     store_pc;
    logic            flush;
    logic [RW-1:0]   retire_valid;
    logic [RW-1:0]   retire_is_store;
    logic [RW*IW-1:0] retire_id;
    logic [RW*5-1:0] retire_rd_addr;
    logic [RW*XL-1:0] retire_rd_data;
    logic [RW*32-1:0] retire_pc;
    logic [1:0]      retire_count;
    logic [IW-1:0]   rs1_id, rs2_id;
    logic            rs1_valid, rs2_valid;
    logic [XL-1:0]   rs1_data, rs2_data;
    logic [IW-1:0]   oldest_id;
    logic            empty;

    int n_cmp = 0;
    int n_bad = 0;

    write_back_multi_retire dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd_addr(issue_rd_addr), .issue_is_store(issue_is_store),
        .issue_id(issue_id), .id_available(id_available),
        .unit_done(unit_done), .unit_id(unit_id), .unit_rd(unit_rd), .unit_pc(unit_pc),
        .store_complete(store_complete), .store_id(store_id), .store_pc(store_pc),
        .flush(flush),
        .retire_valid(retire_valid), .retire_is_store(retire_is_store), .retire_id(retire_id),
        .retire_rd_addr(retire_rd_addr), .retire_rd_data(retire_rd_data), .retire_pc(retire_pc),
        .retire_count(retire_count),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_valid(rs1_valid), .rs2_valid(rs2_valid),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .oldest_id(oldest_id), .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached (compared %0d)", n_cmp);
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid    = 1'b0;
        issue_rd_addr  = 5'd0;
        issue_is_store = 1'b0;
        unit_done      = '0;
        unit_id        = '0;
        unit_rd        = '0;
        unit_pc        = '0;
        store_complete = 1'b0;
        store_id       = '0;
        store_pc       = '0;
        flush          = 1'b0;
    endtask

    task automatic set_unit(input int u, input logic [IW-1:0] id, input logic [31:0] data, input logic [31:0] pc);
        unit_done[u]       = 1'b1;
        unit_id[u*IW +: IW] = id;
        unit_rd[u*XL +: XL] = data;
        unit_pc[u*32 +: 32] = pc;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue_n(input int n, input int first_rd, input int store_at);
        for (int i = 0; i < n; i++) begin
            issue_valid    = 1'b1;
            issue_rd_addr  = 5'(first_rd + i);
            issue_is_store = (i == store_at);
            tick();
        end
        issue_valid    = 1'b0;
        issue_is_store = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL rst_retire_valid got=%b exp=00", retire_valid); end
        n_cmp++; if (retire_count !== 2'd0) begin n_bad++; $display("FAIL rst_retire_count got=%0d exp=0", retire_count); end
        n_cmp++; if (retire_rd_addr !== 10'd0) begin n_bad++; $display("FAIL rst_rd_addr got=%h exp=0", retire_rd_addr); end
        n_cmp++; if (id_available !== 1'b1) begin n_bad++; $display("FAIL rst_id_available got=%b exp=1", id_available); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
        n_cmp++; if (oldest_id !== 3'd0) begin n_bad++; $display("FAIL rst_oldest got=%0d exp=0", oldest_id); end
        n_cmp++; if (issue_id !== 3'd0) begin n_bad++; $display("FAIL rst_issue_id got=%0d exp=0", issue_id); end
    endtask

    task automatic test_out_of_order();
        issue_n(4, 1, -1);
        n_cmp++; if (issue_id !== 3'd4) begin n_bad++; $display("FAIL ooo_issue_id got=%0d exp=4", issue_id); end
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL ooo_empty got=%b exp=0", empty); end
        set_unit(1, 3'd2, 32'h22, 32'h108); tick(); clear_inputs();
        n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL ooo_no_retire_id2 got=%b exp=00", retire_valid); end
        set_unit(0, 3'd0, 32'h10, 32'h100); tick(); clear_inputs();
        n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL ooo_latency got=%b exp=00", retire_valid); end
        set_unit(3, 3'd1, 32'h11, 32'h104); tick(); clear_inputs();
        n_cmp++; if (retire_valid !== 2'b01) begin n_bad++; $display("FAIL ooo_r0_valid got=%b exp=01", retire_valid); end
        n_cmp++; if (retire_id[2:0] !== 3'd0) begin n_bad++; $display("FAIL ooo_r0_id got=%0d exp=0", retire_id[2:0]); end
        n_cmp++; if (retire_rd_addr[4:0] !== 5'd1) begin n_bad++; $display("FAIL ooo_r0_rd got=%0d exp=1", retire_rd_addr[4:0]); end
        n_cmp++; if (retire_rd_data[31:0] !== 32'h10) begin n_bad++; $display("FAIL ooo_r0_data got=%h exp=10", retire_rd_data[31:0]); end
        n_cmp++; if (retire_pc[31:0] !== 32'h100) begin n_bad++; $display("FAIL ooo_r0_pc got=%h exp=100", retire_pc[31:0]); end
        n_cmp++; if (retire_count !== 2'd1) begin n_bad++; $display("FAIL ooo_r0_count got=%0d exp=1", retire_count); end
        set_unit(2, 3'd3, 32'h33, 32'h10c); tick(); clear_inputs();
        n_cmp++; if (retire_valid !== 2'b11) begin n_bad++; $display("FAIL ooo_r12_valid got=%b exp=11", retire_valid); end
        n_cmp++; if (retire_id !== {3'd2, 3'd1}) begin n_bad++; $display("FAIL ooo_r12_ids got=%h exp=%h", retire_id, {3'd2, 3'd1}); end
        n_cmp++; if (retire_rd_addr !== {5'd3, 5'd2}) begin n_bad++; $display("FAIL ooo_r12_rd got=%h exp=%h", retire_rd_addr, {5'd3, 5'd2}); end
        n_cmp++; if (retire_rd_data[63:32] !== 32'h22) begin n_bad++; $display("FAIL ooo_r12_data1 got=%h exp=22", retire_rd_data[63:32]); end
        n_cmp++; if (retire_count !== 2'd2) begin n_bad++; $display("FAIL ooo_r12_count got=%0d exp=2", retire_count); end
        tick();
        n_cmp++; if (retire_valid !== 2'b01) begin n_bad++; $display("FAIL ooo_r3_valid got=%b exp=01", retire_valid); end
        n_cmp++; if (retire_id[2:0] !== 3'd3) begin n_bad++; $display("FAIL ooo_r3_id got=%0d exp=3", retire_id[2:0]); end
        n_cmp++; if (retire_rd_addr[4:0] !== 5'd4) begin n_bad++; $display("FAIL ooo_r3_rd got=%0d exp=4", retire_rd_addr[4:0]); end
        tick();
        n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL ooo_idle got=%b exp=00", retire_valid); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL ooo_empty_end got=%b exp=1", empty); end
        n_cmp++; if (oldest_id !== 3'd4) begin n_bad++; $display("FAIL ooo_oldest_end got=%0d exp=4", oldest_id); end
    endtask

    task automatic test_full_wrap();
        // Starts with alloc pointer and head both at 4.
        for (int i = 0; i < 8; i++) begin
            issue_valid   = 1'b1;
            issue_rd_addr = 5'(5 + i);
            tick();
            if (i == 3) begin
                n_cmp++; if (issue_id !== 3'd0) begin n_bad++; $display("FAIL wrap_issue_id got=%0d exp=0", issue_id); end
            end
        end
        n_cmp++; if (id_available !== 1'b0) begin n_bad++; $display("FAIL full_id_available got=%b exp=0", id_available); end
        tick();
        issue_valid = 1'b0;
        n_cmp++; if (issue_id !== 3'd4) begin n_bad++; $display("FAIL full_issue_ignored got=%0d exp=4", issue_id); end
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL full_empty got=%b exp=0", empty); end
        set_unit(0, 3'd4, 32'h44, 32'h0); set_unit(1, 3'd5, 32'h55, 32'h0); tick(); clear_inputs();
        n_cmp++; if (id_available !== 1'b0) begin n_bad++; $display("FAIL full_still_full got=%b exp=0", id_available); end
        tick();
        n_cmp++; if (retire_valid !== 2'b11) begin n_bad++; $display("FAIL full_r45_valid got=%b exp=11", retire_valid); end
        n_cmp++; if (retire_id !== {3'd5, 3'd4}) begin n_bad++; $display("FAIL full_r45_ids got=%h exp=%h", retire_id, {3'd5, 3'd4}); end
        n_cmp++; if (id_available !== 1'b1) begin n_bad++; $display("FAIL full_freed got=%b exp=1", id_available); end
        set_unit(0, 3'd6, 32'h66, 32'h0); set_unit(1, 3'd7, 32'h77, 32'h0);
        set_unit(2, 3'd0, 32'h80, 32'h0); set_unit(3, 3'd1, 32'h81, 32'h0);
        tick(); clear_inputs();
        set_unit(0, 3'd2, 32'h82, 32'h0); set_unit(1, 3'd3, 32'h83, 32'h0);
        tick(); clear_inputs();
        n_cmp++; if (retire_id !== {3'd7, 3'd6}) begin n_bad++; $display("FAIL wrap_r67_ids got=%h exp=%h", retire_id, {3'd7, 3'd6}); end
        tick();
        n_cmp++; if (retire_id !== {3'd1, 3'd0}) begin n_bad++; $display("FAIL wrap_r01_ids got=%h exp=%h", retire_id, {3'd1, 3'd0}); end
        n_cmp++; if (retire_rd_data[31:0] !== 32'h80) begin n_bad++; $display("FAIL wrap_r0_data got=%h exp=80", retire_rd_data[31:0]); end
        tick();
        tick();
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
        n_cmp++; if (oldest_id !== 3'd4) begin n_bad++; $display("FAIL wrap_oldest got=%0d exp=4", oldest_id); end
    endtask

    task automatic test_store();
        do_reset();
        issue_n(3, 5, 1);
        set_unit(0, 3'd0, 32'hA0, 32'h200);
        set_unit(1, 3'd2, 32'hC0, 32'h208);
        store_complete = 1'b1; store_id = 3'd1; store_pc = 32'h204;
        tick(); clear_inputs();
        tick();
        n_cmp++; if (retire_valid !== 2'b11) begin n_bad++; $display("FAIL st_valid got=%b exp=11", retire_valid); end
        n_cmp++; if (retire_is_store !== 2'b10) begin n_bad++; $display("FAIL st_is_store got=%b exp=10", retire_is_store); end
        n_cmp++; if (retire_count !== 2'd1) begin n_bad++; $display("FAIL st_count got=%0d exp=1", retire_count); end
        n_cmp++; if (retire_rd_addr !== {5'd0, 5'd5}) begin n_bad++; $display("FAIL st_rd_addr got=%h exp=%h", retire_rd_addr, {5'd0, 5'd5}); end
        n_cmp++; if (retire_pc[63:32] !== 32'h204) begin n_bad++; $display("FAIL st_pc got=%h exp=204", retire_pc[63:32]); end
        tick();
        n_cmp++; if (retire_valid !== 2'b01) begin n_bad++; $display("FAIL st_id2_valid got=%b exp=01", retire_valid); end
        n_cmp++; if (retire_rd_addr[4:0] !== 5'd7) begin n_bad++; $display("FAIL st_id2_rd got=%0d exp=7", retire_rd_addr[4:0]); end
        n_cmp++; if (retire_rd_data[31:0] !== 32'hC0) begin n_bad++; $display("FAIL st_id2_data got=%h exp=c0", retire_rd_data[31:0]); end
    endtask

    task automatic test_flush();
        do_reset();
        issue_n(6, 1, -1);
        set_unit(0, 3'd0, 32'h1, 32'h0); tick(); clear_inputs();
        tick();
        n_cmp++; if (retire_valid !== 2'b01) begin n_bad++; $display("FAIL fl_prior_retire got=%b exp=01", retire_valid); end
        n_cmp++; if (oldest_id !== 3'd1) begin n_bad++; $display("FAIL fl_prior_oldest got=%0d exp=1", oldest_id); end
        flush = 1'b1;
        set_unit(0, 3'd2, 32'h2, 32'h0);
        tick(); clear_inputs();
        n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL fl_retire_valid got=%b exp=00", retire_valid); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL fl_empty got=%b exp=1", empty); end
        n_cmp++; if (issue_id !== 3'd1) begin n_bad++; $display("FAIL fl_issue_id got=%0d exp=1", issue_id); end
        rs1_id = 3'd2;
        #1;
        n_cmp++; if (rs1_valid !== 1'b0) begin n_bad++; $display("FAIL fl_id2_pending got=%b exp=0", rs1_valid); end
        tick();
        n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL fl_no_retire got=%b exp=00", retire_valid); end
    endtask

    task automatic test_dual_done();
        do_reset();
        issue_n(5, 1, -1);
        set_unit(0, 3'd4, 32'hAAAA, 32'h0);
        set_unit(2, 3'd4, 32'h5555, 32'h0);
        rs1_id = 3'd4;
        rs2_id = 3'd3;
        tick(); clear_inputs();
        n_cmp++; if (rs1_valid !== 1'b1) begin n_bad++; $display("FAIL dd_rs1_valid got=%b exp=1", rs1_valid); end
        n_cmp++; if (rs1_data !== 32'hAAAA) begin n_bad++; $display("FAIL dd_rs1_data got=%h exp=aaaa", rs1_data); end
        n_cmp++; if (rs2_valid !== 1'b0) begin n_bad++; $display("FAIL dd_rs2_valid got=%b exp=0", rs2_valid); end
        tick();
        n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL dd_head_blocks got=%b exp=00", retire_valid); end
    endtask

    task automatic test_reset_mid();
        // Continues from the dual-done state: ID 4 already pending.
        set_unit(1, 3'd1, 32'h11, 32'h0);
        set_unit(3, 3'd2, 32'h22, 32'h0);
        rs2_id = 3'd2;
        tick(); clear_inputs();
        n_cmp++; if (rs2_valid !== 1'b1 || rs2_data !== 32'h22) begin n_bad++; $display("FAIL rm_pre_bypass got=%b/%h exp=1/22", rs2_valid, rs2_data); end
        rst = 1'b1;
        tick();
        n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL rm_retire_valid got=%b exp=00", retire_valid); end
        n_cmp++; if (retire_count !== 2'd0) begin n_bad++; $display("FAIL rm_retire_count got=%0d exp=0", retire_count); end
        n_cmp++; if (empty !== 1'b1 || id_available !== 1'b1) begin n_bad++; $display("FAIL rm_empty_avail got=%b%b exp=11", empty, id_available); end
        n_cmp++; if (issue_id !== 3'd0 || oldest_id !== 3'd0) begin n_bad++; $display("FAIL rm_pointers got=%0d/%0d exp=0/0", issue_id, oldest_id); end
        n_cmp++; if (rs1_valid !== 1'b0 || rs2_valid !== 1'b0) begin n_bad++; $display("FAIL rm_pending got=%b%b exp=00", rs1_valid, rs2_valid); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL rm_quiet_%0d got=%b exp=00", i, retire_valid); end
        end
    endtask

    initial begin
        rst    = 1'b1;
        rs1_id = '0;
        rs2_id = '0;
        clear_inputs();
        test_reset();
        test_out_of_order();
        test_full_wrap();
        test_store();
        test_flush();
        test_dual_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
